// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the execute-stage ALU and the ALU controller.
//   - alu_op_e     : 4-bit Operation code issued by the controller
//   - alu_state_e  : control states of the execute unit
//   - WIDTH_DEFAULT: default operand/result width
//   - is_shift_op  : true for operations routed to the serial shifter
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_BEQ  = 4'b1001,
        OP_BNE  = 4'b1010,
        OP_BLT  = 4'b1011,
        OP_BGE  = 4'b1100,
        OP_SLTU = 4'b1101,
        OP_BLTU = 4'b1110,
        OP_BGEU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// ---------------------------------------------------------------------------
// serial_shifter
//   Shifts an accumulator by one bit per clock until the loaded count runs
//   out. Direction and fill mode are captured at load time.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     load        : capture data_in / shamt / shift_left / arith
//     data_in     : value to shift
//     shamt       : number of single-bit shifts to perform
//     shift_left  : 1 = shift left (zero fill), 0 = shift right
//     arith       : right shifts replicate the MSB when set
//     acc_next    : accumulator value after the shift of this cycle
//     busy        : shifts remain (count non-zero)
//     done        : this cycle performs the final shift; acc_next is final
// ---------------------------------------------------------------------------
module serial_shifter
    import alu_pkg::*;
#(
    parameter int   WIDTH   = WIDTH_DEFAULT,
    localparam int  SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               shift_left,
    input  logic               arith,
    output logic [WIDTH-1:0]   acc_next,
    output logic               busy,
    output logic               done
);

    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic               left_q;
    logic               arith_q;

    assign busy = (cnt != '0);
    assign done = (cnt == SHAMT_W'(1));

    // Right fill bit is the old MSB only for arithmetic shifts.
    assign acc_next = left_q ? {acc[WIDTH-2:0], 1'b0}
                             : {arith_q & acc[WIDTH-1], acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            acc     <= data_in;
            cnt     <= shamt;
            left_q  <= shift_left;
            arith_q <= arith;
        end else if (busy) begin
            acc     <= acc_next;
            cnt     <= cnt - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU. Single-cycle logic/arithmetic/compare operations and
//   serial (1 bit per cycle) shifts, with valid/ready handshakes on both
//   sides and a registered result.
//   Ports:
//     clk, reset    : clock, asynchronous active-high reset
//     in_valid      : operation and operands presented
//     in_ready      : operation accepted this cycle when in_valid is high
//     operation     : 4-bit Operation code (alu_op_e)
//     src_a, src_b  : operands; shifts use src_b[SHAMT_W-1:0] as amount
//     out_valid     : result/branch_taken/zero hold a valid result
//     out_ready     : consumer takes the result this cycle
//     result        : registered ALU result
//     branch_taken  : branch condition for branch codes, else 0
//     zero          : registered result equals zero
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             branch_taken,
    output logic             zero
);

    localparam int SHAMT_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] flag_word(input logic c);
        return {{(WIDTH-1){1'b0}}, c};
    endfunction

    alu_state_e          state;
    alu_state_e          state_next;
    alu_op_e             op;
    logic                accept;
    logic                pop;
    logic                op_is_shift;
    logic [SHAMT_W-1:0]  shamt;

    logic                sh_load;
    logic                sh_busy;
    logic                sh_done;
    logic [WIDTH-1:0]    sh_acc_next;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                lt_s;
    logic                lt_u;
    logic                eq;
    logic [WIDTH-1:0]    alu_res;
    logic                alu_br;

    assign op          = alu_op_e'(operation);
    assign shamt       = src_b[SHAMT_W-1:0];
    assign op_is_shift = is_shift_op(op);

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign sh_load   = accept && op_is_shift;

    // ---- single-cycle datapath ---------------------------------------------
    assign a_s  = src_a;
    assign b_s  = src_b;
    assign lt_s = (a_s < b_s);
    assign lt_u = (src_a < src_b);
    assign eq   = (src_a == src_b);

    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        case (op)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLT:  alu_res = flag_word(lt_s);
            OP_SLTU: alu_res = flag_word(lt_u);
            OP_BEQ: begin
                alu_br  = eq;
                alu_res = flag_word(eq);
            end
            OP_BNE: begin
                alu_br  = !eq;
                alu_res = flag_word(!eq);
            end
            OP_BLT: begin
                alu_br  = lt_s;
                alu_res = flag_word(lt_s);
            end
            OP_BGE: begin
                alu_br  = !lt_s;
                alu_res = flag_word(!lt_s);
            end
            OP_BLTU: begin
                alu_br  = lt_u;
                alu_res = flag_word(lt_u);
            end
            OP_BGEU: begin
                alu_br  = !lt_u;
                alu_res = flag_word(!lt_u);
            end
            // Shift codes produce their value through the serial shifter.
            default: begin
                alu_res = '0;
                alu_br  = 1'b0;
            end
        endcase
    end

    // ---- serial shifter ----------------------------------------------------
    serial_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (sh_load),
        .data_in    (src_a),
        .shamt      (shamt),
        .shift_left (op == OP_SLL),
        .arith      (op == OP_SRA),
        .acc_next   (sh_acc_next),
        .busy       (sh_busy),
        .done       (sh_done)
    );

    // ---- control FSM -------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (pop) begin
                    state_next = IDLE;
                end
                // A pop and a new accept may share a cycle (back-to-back).
                if (accept) begin
                    state_next = (op_is_shift && (shamt != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    state_next = DONE;
                end else if (!sh_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---- result registers --------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result       <= '0;
            branch_taken <= 1'b0;
            zero         <= 1'b0;
        end else if (accept) begin
            if (op_is_shift) begin
                // Final for a zero shift amount; otherwise overwritten when
                // the shifter finishes.
                result       <= src_a;
                branch_taken <= 1'b0;
                zero         <= (src_a == '0);
            end else begin
                result       <= alu_res;
                branch_taken <= alu_br;
                zero         <= (alu_res == '0);
            end
        end else if ((state == SHIFT) && sh_done) begin
            result       <= sh_acc_next;
            branch_taken <= 1'b0;
            zero         <= (sh_acc_next == '0);
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   operation;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         branch_taken;
    logic         zero;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .operation    (operation),
        .src_a        (src_a),
        .src_b        (src_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .zero         (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         br;
        logic         z;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         br;
        logic         z;
        int           lat;
    } vec_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;
    logic rand_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model built from the language operators.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa = a;
        logic signed [W-1:0] sb = b;
        logic [4:0] sh = b[4:0];
        logic lts = sa < sb;
        logic ltu = a < b;
        logic c = 1'b0;
        exp_t e;
        e.res = '0;
        e.br  = 1'b0;
        case (op)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  e.res = a + b;
            4'd3:  e.res = a - b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = {31'd0, lts};
            4'd6:  e.res = a << sh;
            4'd7:  e.res = a >> sh;
            4'd8:  e.res = sa >>> sh;
            4'd13: e.res = {31'd0, ltu};
            default: begin
                case (op)
                    4'd9:    c = (a == b);
                    4'd10:   c = (a != b);
                    4'd11:   c = lts;
                    4'd12:   c = !lts;
                    4'd14:   c = ltu;
                    default: c = !ltu;
                endcase
                e.br  = c;
                e.res = {31'd0, c};
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on output transfer.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: result %0h with no expected entry", result);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_pops++;
                    if ({result, branch_taken, zero} !== mon_e) begin
                        n_fail++;
                        $display("FAIL sb_result: got res=%0h br=%0b z=%0b expected res=%0h br=%0b z=%0b",
                                 result, branch_taken, zero, mon_e.res, mon_e.br, mon_e.z);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(exp_cur);
        end
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, output logic ok);
        operation = op;
        src_a     = a;
        src_b     = b;
        exp_cur   = e;
        in_valid  = 1'b1;
        ok        = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    vec_t vecs[$];
    logic ok;
    int   lat;
    int   seen;
    int   issued;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        operation = '0;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b1;
        exp_cur   = '0;
        repeat (2) step();

        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_branch", branch_taken, 0);
        check("rst_zero", zero, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        //            op     a             b             res           br    z     lat
        vecs.push_back('{4'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd1,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd2,  32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1});
        vecs.push_back('{4'd2,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b1, 1});
        vecs.push_back('{4'd3,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd4,  32'h000000F0, 32'h000000FF, 32'h0000000F, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd5,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1});
        vecs.push_back('{4'd13, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b1, 1});
        vecs.push_back('{4'd6,  32'h00001234, 32'd0,        32'h00001234, 1'b0, 1'b0, 1});
        vecs.push_back('{4'd6,  32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 32});
        vecs.push_back('{4'd7,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 5});
        vecs.push_back('{4'd8,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 5});
        vecs.push_back('{4'd8,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 5});
        vecs.push_back('{4'd9,  32'd9,        32'd9,        32'd1,        1'b1, 1'b0, 1});
        vecs.push_back('{4'd10, 32'd9,        32'd9,        32'd0,        1'b0, 1'b1, 1});
        vecs.push_back('{4'd11, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1'b0, 1});
        vecs.push_back('{4'd12, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b1, 1});
        vecs.push_back('{4'd14, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b1, 1});
        vecs.push_back('{4'd15, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1'b0, 1});

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, '{vecs[i].res, vecs[i].br, vecs[i].z}, ok);
            src_a = $urandom();
            src_b = $urandom();
            operation = 4'($urandom_range(0, 15));
            wait_out(lat);
            check($sformatf("latency_op%0d_vec%0d", vecs[i].op, i), lat, vecs[i].lat);
        end
        step();

        // SRA stall: in_ready low for all four shift cycles.
        issue(4'd8, 32'h80000000, 32'd4, '{32'hF8000000, 1'b0, 1'b0}, ok);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (!in_ready && !out_valid) seen++;
            step();
        end
        check("sra_stall_cycles", seen, 4);
        check("sra_out_valid", out_valid, 1);
        step();

        // Backpressure then same-cycle pop and accept.
        out_ready = 1'b0;
        issue(4'd2, 32'd5, 32'd7, '{32'd12, 1'b0, 1'b0}, ok);
        wait_out(lat);
        check("bp_latency", lat, 1);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            operation = 4'd3;
            src_a     = 32'd100;
            src_b     = 32'd1;
            exp_cur   = '{32'hDEADBEEF, 1'b1, 1'b1};
            if (result === 32'd12 && !in_ready && out_valid && !zero) seen++;
            step();
        end
        check("bp_hold_cycles", seen, 3);
        out_ready = 1'b1;
        operation = 4'd4;
        src_a     = 32'h000000F0;
        src_b     = 32'h000000FF;
        exp_cur   = '{32'h0000000F, 1'b0, 1'b0};
        #1;
        check("bp_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_result", result, 32'h0000000F);
        step();

        // Reset in the middle of a long shift.
        issue(4'd7, 32'hFFFFFFFF, 32'd31, model(4'd7, 32'hFFFFFFFF, 32'd31), ok);
        repeat (9) step();
        check("mid_shift_busy", {out_valid, in_ready}, 2'b00);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_zero", zero, 0);
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen++;
            step();
        end
        check("mid_rst_no_output", seen, 0);

        // Random sweep with input gaps and output backpressure.
        n_pops  = 0;
        issued  = 0;
        rand_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            logic [3:0]   rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            repeat ($urandom_range(0, 2)) step();
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom();
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom();
            if ($urandom_range(0, 1) == 0) rb = rb & 32'h0000000F;
            issue(rop, ra, rb, model(rop, ra, rb), ok);
            if (ok) issued++;
            src_a     = $urandom();
            src_b     = $urandom();
            operation = 4'($urandom_range(0, 15));
        end
        rand_en = 1'b0;
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
        check("sweep_queue_empty", exp_q.size(), 0);
        check("sweep_count", n_pops, issued);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
